adc_spi_responder: RTL
======================

ADC_SPI_RESPONDER -- requirements
Module: adc_spi_responder

Interface
REQ-001 Clk  in  1  system clock; all logic rising-edge on Clk.
REQ-002 Rst_n  in  1  reset; one clock, asynchronous, active-low.
REQ-003 ADC_SCLK  in  1  serial clock from master; idles high; asynchronous to Clk.
REQ-004 ADC_CS_N  in  1  chip select from master, active-low; asynchronous to Clk.
REQ-005 ADC_DIN  in  1  address bits from master, sampled on ADC_SCLK rising edge.
REQ-006 ADC_DOUT  out  1  conversion data to master, changed after ADC_SCLK falling edge.
REQ-007 ADC_DOUT_OE  out  1  high while a frame is selected (synchronized CS_N low).
REQ-008 Wr_En / Wr_Addr[2:0] / Wr_Data[11:0]  in  1/3/12  write port to the 8x12 sample bank.
REQ-009 Frame_Done  out  1  one-Clk pulse per completed 16-bit frame.
REQ-010 Conv_Chan  out  3  channel whose sample the current frame shifts out.

Function
REQ-011 ADC_SCLK, ADC_CS_N, ADC_DIN each pass through a 2-flop synchronizer; SCLK edges are detected from the synchronized copy.
REQ-012 Operating constraint: each ADC_SCLK high and low phase lasts at least 4 Clk periods.
REQ-013 FSM states: IDLE (synced CS_N high), LOAD (one cycle after CS_N fall), SHIFT (CS_N low).
REQ-014 IDLE->LOAD on synced CS_N falling; LOAD->SHIFT unconditionally; SHIFT->IDLE on synced CS_N rising.
REQ-015 In LOAD: 16-bit shift register loads {4'b0000, bank[Conv_Chan]}; 4-bit bit counter cleared.
REQ-016 ADC_DOUT equals shift register bit 15 while ADC_DOUT_OE is high, 0 otherwise.
REQ-017 On each SCLK rising edge in SHIFT: bit counter increments; DIN captured into address shift register.
REQ-018 Rising edges 3, 4, 5 of a frame (1-based) capture ADD2, ADD1, ADD0; all other DIN bits are ignored.
REQ-019 On each SCLK falling edge in SHIFT, the shift register shifts left by one only if bit counter is nonzero.
REQ-020 On the 16th rising edge: counter wraps to 0, Conv_Chan <= captured address, shift register reloads {4'b0000, bank[captured address]}, Frame_Done pulses.
REQ-021 CS_N may stay low across frames; back-to-back frames follow REQ-020 without returning to IDLE.
REQ-022 First frame after reset converts channel 0; each later frame converts the address received in the preceding complete frame.
REQ-023 CS_N rising mid-frame aborts: no Frame_Done, Conv_Chan unchanged, partial address discarded.
REQ-024 ADC_DOUT latency: at most 3 Clk cycles after the ADC_SCLK falling edge or CS_N falling edge.
REQ-025 A Wr_En write to bank[Wr_Addr] takes effect the next cycle; a write coinciding with a load of that same entry bypasses, so Wr_Data is loaded.

Reset
REQ-026 On Rst_n low: FSM IDLE, ADC_DOUT 0, ADC_DOUT_OE 0, Frame_Done 0, Conv_Chan 0, counters 0, all bank entries 0, synchronizers 1 (idle).
REQ-027 Reset asserted mid-frame abandons the frame immediately; after release a new CS_N fall is required to start a frame.

Configuration
REQ-028 Macro ADC_RESP_AUTO_INC_EN: when defined, each Frame_Done increments bank[converted channel] by 1 mod 4096; a same-cycle Wr_En write to that entry takes priority over the increment.
REQ-029 Without ADC_RESP_AUTO_INC_EN, bank contents change only through the write port.

Verification
REQ-030 Write bank[0]=0xABC; CS_N low; one frame with DIN address 3 -> master captures 0x0ABC (4 leading zeros); Frame_Done pulses once; Conv_Chan=3.
REQ-031 Bank[3]=0x555 and CS_N held low; second frame, address 5 -> 16 bits 0x0555; Conv_Chan=5 after the frame.
REQ-032 CS_N raised after 9 SCLK edges with DIN address 6 -> no Frame_Done, Conv_Chan unchanged; next full frame outputs the old channel's data.
REQ-033 Rst_n pulsed low mid-frame -> all outputs return to REQ-026 values within 1 Clk; the next frame returns bank[0]=0x000.
REQ-034 With ADC_RESP_AUTO_INC_EN and bank[0]=0xFFF, two frames at address 0 -> data 0xFFF then 0x000.
REQ-035 Wr_En to bank[2]=0x123 in the same cycle as the LOAD of channel 2 -> the frame shifts out 0x0123.

Source files
------------

// File: rtl/adc_spi_responder.sv
// adc_spi_responder
//
// Emulates the data side of a 12-bit, 8-channel serial ADC. A master selects
// the part with ADC_CS_N, clocks 16-bit frames with ADC_SCLK (idle high) and
// sends a channel address on ADC_DIN. Each frame shifts out
// {4'b0000, sample} MSB first for the channel addressed in the previous
// completed frame. The samples come from an 8x12 bank filled through a
// simple write port.
//
// Handshake / timing:
//   The serial pins are asynchronous to Clk. Each pin passes through a two-flop
//   synchronizer. SCLK edges are taken from the synchronized copy, so the master
//   must hold every SCLK phase for at least 4 Clk periods. ADC_DOUT changes
//   within 3 Clk cycles of an SCLK falling edge. The master samples it on the
//   next SCLK rising edge.
//
// Optional feature: define ADC_RESP_AUTO_INC_EN to make every completed frame
// add 1 (mod 4096) to the converted channel's bank entry. A write on the same
// cycle to the same entry wins over the increment.
//
// Ports:
//   Clk, Rst_n          system clock, asynchronous active-low reset
//   ADC_SCLK/CS_N/DIN   serial inputs from the master (asynchronous)
//   ADC_DOUT            serial data to the master
//   ADC_DOUT_OE         high while a frame is selected
//   Wr_En/Addr/Data     sample bank write port
//   Frame_Done          one-cycle pulse per completed 16-bit frame
//   Conv_Chan           channel whose sample the current frame carries
module adc_spi_responder (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        ADC_SCLK,
  input  logic        ADC_CS_N,
  input  logic        ADC_DIN,
  output logic        ADC_DOUT,
  output logic        ADC_DOUT_OE,
  input  logic        Wr_En,
  input  logic [2:0]  Wr_Addr,
  input  logic [11:0] Wr_Data,
  output logic        Frame_Done,
  output logic [2:0]  Conv_Chan
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  // Synchronizers. They reset to 1 because SCLK and CS_N idle high.
  logic        sclk_s1, sclk_s2, sclk_d;
  logic        cs_s1, cs_s2, cs_d;
  logic        din_s1, din_s2;

  // warm_cnt lets the CS_N synchronizer fill with the real pin value after
  // reset. cs_armed then requires that the master shows CS_N high before a fall
  // is accepted. As a result, a CS_N held low through reset cannot start a frame.
  logic [1:0]  warm_cnt;
  logic        cs_armed;

  logic [15:0] shift_sr;
  logic [3:0]  bit_cnt;
  logic [2:0]  addr_sr;
  logic [11:0] bank [8];

  logic        sclk_rise, sclk_fall, cs_fall;
  logic        load_en, shift_active, frame_end;
  logic [11:0] load_data, reload_data;

  assign sclk_rise = sclk_s2 & ~sclk_d;
  assign sclk_fall = ~sclk_s2 & sclk_d;
  assign cs_fall   = cs_armed & cs_d & ~cs_s2;
  assign frame_end = shift_active & sclk_rise & (bit_cnt == 4'd15);

  // Input synchronization and edge history
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sclk_s1  <= 1'b1;
      sclk_s2  <= 1'b1;
      sclk_d   <= 1'b1;
      cs_s1    <= 1'b1;
      cs_s2    <= 1'b1;
      cs_d     <= 1'b1;
      din_s1   <= 1'b1;
      din_s2   <= 1'b1;
      warm_cnt <= 2'd0;
      cs_armed <= 1'b0;
    end else begin
      sclk_s1  <= ADC_SCLK;
      sclk_s2  <= sclk_s1;
      sclk_d   <= sclk_s2;
      cs_s1    <= ADC_CS_N;
      cs_s2    <= cs_s1;
      cs_d     <= cs_s2;
      din_s1   <= ADC_DIN;
      din_s2   <= din_s1;
      if (!warm_cnt[1]) warm_cnt <= warm_cnt + 2'd1;
      if (warm_cnt[1] && cs_s2) cs_armed <= 1'b1;
    end
  end

  // FSM: state register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (cs_fall) state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = ST_SHIFT;
      ST_SHIFT: if (cs_s2) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // FSM: outputs. The shift register is held at zero in IDLE. This keeps
  // DOUT at the correct leading zero during the LOAD cycle.
  always_comb begin
    load_en      = (state == ST_LOAD);
    shift_active = (state == ST_SHIFT) && !cs_s2;
    ADC_DOUT_OE  = (state != ST_IDLE);
    ADC_DOUT     = ADC_DOUT_OE & shift_sr[15];
  end

  // Bank read with write-through bypass. With auto-increment, the end-of-frame
  // reload also sees the value that the increment writes on the same edge.
  always_comb begin
    load_data = bank[Conv_Chan];
    if (Wr_En && (Wr_Addr == Conv_Chan)) load_data = Wr_Data;
    reload_data = bank[addr_sr];
`ifdef ADC_RESP_AUTO_INC_EN
    if (addr_sr == Conv_Chan) reload_data = bank[Conv_Chan] + 12'd1;
`endif
    if (Wr_En && (Wr_Addr == addr_sr)) reload_data = Wr_Data;
  end

  // Frame datapath
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      shift_sr   <= 16'd0;
      bit_cnt    <= 4'd0;
      addr_sr    <= 3'd0;
      Conv_Chan  <= 3'd0;
      Frame_Done <= 1'b0;
    end else begin
      Frame_Done <= frame_end;
      if (state == ST_IDLE) begin
        shift_sr <= 16'd0;
      end else if (load_en) begin
        shift_sr <= {4'b0000, load_data};
        bit_cnt  <= 4'd0;
        addr_sr  <= 3'd0;
      end else if (shift_active) begin
        if (sclk_rise) begin
          bit_cnt <= bit_cnt + 4'd1;  // wraps to 0 on the 16th edge
          // Rising edges 3..5 (count 2..4 before increment) carry ADD2..ADD0
          if ((bit_cnt >= 4'd2) && (bit_cnt <= 4'd4))
            addr_sr <= {addr_sr[1:0], din_s2};
          if (frame_end) begin
            Conv_Chan <= addr_sr;
            shift_sr  <= {4'b0000, reload_data};
          end
        end else if (sclk_fall && (bit_cnt != 4'd0)) begin
          // The first fall of a frame leaves bit 15 in place for rising edge 1
          shift_sr <= {shift_sr[14:0], 1'b0};
        end
      end
    end
  end

  // Sample bank. A write is placed after the increment, so it wins on a
  // collision.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < 8; i++) bank[i] <= 12'd0;
    end else begin
`ifdef ADC_RESP_AUTO_INC_EN
      if (frame_end) bank[Conv_Chan] <= bank[Conv_Chan] + 12'd1;
`endif
      if (Wr_En) bank[Wr_Addr] <= Wr_Data;
    end
  end

endmodule
